// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-to-parallel receiver and its upstream shifter.
package sipo_pkg;

    localparam int SIPO_DATA_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/sipo_rx_if.sv
// Serial input and parallel valid/ready output bundle of sipo_rx.
interface sipo_rx_if
    import sipo_pkg::*;
#(
    parameter int DATA_WIDTH = SIPO_DATA_WIDTH
);
    logic                  s_in;
    logic                  s_en;
    logic                  s_start;
    logic [DATA_WIDTH-1:0] p_out;
    logic                  p_valid;
    logic                  p_ready;
    logic                  busy;
    logic                  overrun;
    logic                  par_err;

    // Driver of the serial stream and consumer of the parallel words.
    modport master (
        output s_in, s_en, s_start, p_ready,
        input  p_out, p_valid, busy, overrun, par_err
    );

    // The receiver itself.
    modport slave (
        input  s_in, s_en, s_start, p_ready,
        output p_out, p_valid, busy, overrun, par_err
    );
endinterface

// File: rtl/sipo_out_buf.sv
// Single-word valid/ready holding register; a word arriving while full and stalled is
// dropped and latches a sticky overrun flag.
module sipo_out_buf
    import sipo_pkg::*;
#(
    parameter int DATA_WIDTH = SIPO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_perr,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_perr,
    output logic                  overrun
);
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ovr_q, ovr_d;
    logic                  load;

    // A completing word may take the slot in the same cycle the old one is consumed.
    assign load = wr_en && (!valid_q || rd_ready);

    always_comb begin
        data_d  = data_q;
        perr_d  = perr_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (load) begin
            data_d  = wr_data;
            perr_d  = wr_perr;
            valid_d = 1'b1;
        end else if (valid_q && rd_ready) begin
            valid_d = 1'b0;
        end
        if (wr_en && valid_q && !rd_ready) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            perr_q  <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            perr_q  <= perr_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rd_data  = data_q;
    assign rd_valid = valid_q;
    assign rd_perr  = perr_q;
    assign overrun  = ovr_q;
endmodule

// File: rtl/sipo_rx.sv
// MSB-first serial-to-parallel receiver feeding a one-word valid/ready buffer.
// Define SIPO_RX_PARITY_EN to expect a trailing even-parity bit per frame.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int DATA_WIDTH = SIPO_DATA_WIDTH,
    parameter int CNT_WIDTH  = 3
) (
    input logic      clk,
    input logic      rst,
    sipo_rx_if.slave bus
);
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d, sr_shift;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_perr;
    logic                  last_data;

    assign sr_shift  = {sr_q[DATA_WIDTH-2:0], bus.s_in};
    assign last_data = (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1));

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_data = sr_shift;
        wr_perr = 1'b0;
        if (bus.s_en) begin
            // s_start wins in every state: a fresh frame discards any partial word.
            if (bus.s_start) begin
                state_d = ST_SHIFT;
                sr_d    = DATA_WIDTH'(bus.s_in);
                cnt_d   = CNT_WIDTH'(1);
            end else begin
                case (state_q)
                    ST_SHIFT: begin
                        sr_d  = sr_shift;
                        cnt_d = cnt_q + 1'b1;
                        if (last_data) begin
`ifdef SIPO_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_IDLE;
                            wr_en   = 1'b1;
                            cnt_d   = '0;
`endif
                        end
                    end
`ifdef SIPO_RX_PARITY_EN
                    ST_PARITY: begin
                        state_d = ST_IDLE;
                        wr_en   = 1'b1;
                        wr_data = sr_q;
                        wr_perr = (^sr_q) ^ bus.s_in;
                        cnt_d   = '0;
                    end
`endif
                    default: ;
                endcase
            end
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

`ifndef SIPO_RX_PARITY_EN
    // Without parity the completed word comes from the shift path, so the MSB flop is never read.
    logic unused_sr_msb;
    assign unused_sr_msb = sr_q[DATA_WIDTH-1];
`endif

    assign bus.busy = busy_q;

    sipo_out_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_perr  (wr_perr),
        .rd_ready (bus.p_ready),
        .rd_data  (bus.p_out),
        .rd_valid (bus.p_valid),
        .rd_perr  (bus.par_err),
        .overrun  (bus.overrun)
    );
endmodule

// File: doc/sipo_rx.md
Name: sipo_rx

Overview:
- Serial-to-parallel receiver. Sits directly downstream of the team's parallel-in/serial-out shifter and consumes its MSB-first serial stream.
- Assembles DATA_WIDTH-bit words and presents each on a one-word output buffer with a valid/ready handshake.
- Flags overruns when the consumer stalls.

Parameters:
- DATA_WIDTH, 4, word width in bits. Must be at least 2.
- CNT_WIDTH, 3, bit-counter width. Must satisfy 2^CNT_WIDTH > DATA_WIDTH (+1 when PARITY_EN is defined).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- s_in  in  1  serial data bit, MSB first
- s_en  in  1  s_in is a valid bit this cycle
- s_start  in  1  with s_en, marks the first (MSB) bit of a frame
- p_out  out  DATA_WIDTH  assembled word
- p_valid  out  1  p_out holds an unconsumed word
- p_ready  in  1  consumer accepts p_out this cycle
- busy  out  1  frame reception in progress
- overrun  out  1  sticky; a completed word was dropped
- par_err  out  1  parity error on the word in p_out (PARITY_EN only; tied 0 otherwise)

Behaviour:
- Reset, synchronous: on a rising clk edge with rst=1, state=IDLE and the shift register and counter clear. Outputs: p_out=0, p_valid=0, busy=0, overrun=0, par_err=0. Reset mid-frame discards the partial word. rst has priority over every other input.
- FSM states: IDLE, SHIFT.
- IDLE:
  - s_en=1 and s_start=1: load s_in into the shift register LSB, count=1, go to SHIFT, busy=1 from the next cycle.
  - s_en=1 and s_start=0: bit is ignored.
  - s_en=0: hold.
- SHIFT:
  - On each s_en=1, the shift register becomes {sr[DATA_WIDTH-2:0], s_in} and count increments.
  - s_en=0 inserts wait cycles; state is held.
  - s_start=1 seen in SHIFT restarts the frame: s_in becomes the new first bit, count=1, and the partial word is dropped without setting overrun.
- Frame completion: when the DATA_WIDTH-th bit is taken (without PARITY_EN), the full word {sr[DATA_WIDTH-2:0], s_in} is transferred to the output buffer on that same edge, and state returns to IDLE.
- Latency: p_valid rises on the clock edge that samples the last bit. It is visible the cycle after the last s_en.
- Output buffer:
  - Buffer empty, or p_valid=1 and p_ready=1 in the same cycle as completion: the new word loads and p_valid stays or becomes 1.
  - p_valid=1 and p_ready=0 at completion: the new word is dropped, the buffer keeps the old word, and overrun is set.
  - p_ready=1 with p_valid=1 and no completion: p_valid clears next cycle. p_out holds its last value.
- overrun is sticky and clears only on rst.
- A back-to-back frame (s_start on the cycle right after completion) must be accepted. IDLE reacts to s_start in the same cycle.

Optional Feature:
- Macro: SIPO_RX_PARITY_EN.
- Defined: each frame carries DATA_WIDTH data bits followed by one even-parity bit.
  - The FSM gains a PARITY state, entered after the last data bit.
  - In PARITY, the next s_en bit completes the frame.
  - par_err = (XOR of the data bits) XOR (parity bit). It loads together with p_out under the same buffer rules and is dropped with the word on overrun.
  - s_start in PARITY restarts the frame as in SHIFT.
- Undefined: no PARITY state, and par_err is tied to 0.

Decomposition:
- Shared package sipo_pkg holds:
  - FSM state encoding constants: ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_PARITY=2'd2.
  - DATA_WIDTH default, shared with the upstream shifter.
- One natural sub-module: sipo_out_buf, the single-word valid/ready holding register with overrun detection. It is instantiated once.
- Shift register, counter and FSM stay in sipo_rx.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, s_en=0 → p_valid=0, busy=0, overrun=0, p_out=0.
- Basic frame: s_start+s_en with bits 1,0,1,1 on consecutive cycles, p_ready=1 → p_out=4'hB, p_valid=1 for exactly one cycle after the 4th bit.
- Gapped frame: bits 0,1,1,0 with s_en low for 2 cycles between each bit → p_out=4'h6, busy=1 throughout the gaps.
- Overrun: p_ready=0, frame 4'hA then back-to-back frame 4'h5 → p_out stays 4'hA, overrun=1. Raise p_ready → p_valid clears, overrun stays 1 until rst.
- Restart and reset mid-frame: bits 1,1 then s_start with 0,0,1,1 → p_out=4'h3. Separately, rst asserted after 2 bits of a frame → no word produced, busy=0.
- Parity (SIPO_RX_PARITY_EN defined): 4'hB followed by parity 1 → par_err=0. 4'hB followed by parity 0 → par_err=1.
